// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter that serialises read/write accesses onto a
// single 16x8 RAM port with a fixed 3-cycle grant/access/response sequence.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | RAM driven with the latched request; write commits at exit
// RESP   | ack pulsed to the winner; read data already captured
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              ptr_q;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt0_q, gnt1_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant;
    logic              grant_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Master 1 wins when it is the only requester or holds the pointer.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_win = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    grant_win = req1 && (!req0 || ptr_q);
                    state_d   = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        ram_we = (state_q == ACCESS) && we_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt0_q <= grant && !grant_win;
            gnt1_q <= grant && grant_win;
            ack0_q <= (state_q == ACCESS) && !win_q;
            ack1_q <= (state_q == ACCESS) && win_q;
            if (grant) begin
                ptr_q   <= !grant_win;
                win_q   <= grant_win;
                we_q    <= grant_win ? we1 : we0;
                addr_q  <= grant_win ? addr1 : addr0;
                wdata_q <= grant_win ? wdata1 : wdata0;
            end
            if ((state_q == ACCESS) && !we_q) begin
                if (win_q) begin
                    rdata1_q <= ram_rdata;
                end else begin
                    rdata0_q <= ram_rdata;
                end
            end
        end
    end

    // Address/data registers only change on a grant, so the RAM port holds
    // its last values outside ACCESS.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule
